coinc_event_framer: RTL and testbench

- Sits between the eight per-channel MPPC discriminator outputs and the byte-serial UART transmitter.
- Synchronises the channel pulses and detects rising edges.
- Groups hits that fall inside a fixed coincidence window into one event, and tags each event with a free-running timestamp.
- Buffers events in a FIFO and emits each one as a 5-byte record over a valid/ready byte handshake.

---
 rtl/coinc_event_framer.sv | 193 +++++++++++++++++++
 tb/tb_coinc_event_framer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/coinc_event_framer.sv
// Coincidence event framer: synchronises MPPC discriminator pulses, groups hits
// inside a fixed window into timestamped events, buffers them, and emits 5-byte records.
module coinc_event_framer #(
  parameter int N_CH       = 8,
  parameter int TS_WIDTH   = 24,
  parameter int WINDOW     = 8,
  parameter int MIN_FOLD   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            booted,
  input  logic [N_CH-1:0] ch_in,
  input  logic [N_CH-1:0] ch_enable,
  output logic [7:0]      byte_data,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic            event_strobe,
  output logic [7:0]      drop_count
);

  localparam int EW = N_CH + TS_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CNT_INIT = 8'(WINDOW - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_COMMIT} state_t;

  // ---------------------------------------------------------------- input path
  logic [N_CH-1:0] s1_q, s2_q, s3_q, hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      hit_q <= '0;
    end else begin
      s1_q  <= ch_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      hit_q <= s2_q & ~s3_q & ch_enable & {N_CH{booted}};
    end
  end

  // ---------------------------------------------------------------- timestamp
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts_q <= '0;
    else if (booted) ts_q <= ts_q + 1'b1;
    else             ts_q <= '0;
  end

  // ---------------------------------------------------------------- coincidence FSM
  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [N_CH-1:0]     mask_q;
  logic [TS_WIDTH-1:0] ts_evt_q;
  logic                event_strobe_q;
  logic [7:0]          drop_count_q;

  logic fold_ok, commit, fifo_full, fifo_empty, fifo_wr, fifo_pop;

  function automatic int unsigned popcnt(input logic [N_CH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < N_CH; i++) n += int'(v[i]);
    return n;
  endfunction

  assign fold_ok = popcnt(mask_q) >= MIN_FOLD;
  assign commit  = (state_q == S_COMMIT);
  // Full is judged on the pre-pop occupancy, so a same-cycle pop never rescues a write.
  assign fifo_wr = commit & fold_ok & ~fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mask_q         <= '0;
      ts_evt_q       <= '0;
      event_strobe_q <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      event_strobe_q <= fifo_wr;
      if (commit && fold_ok && fifo_full && drop_count_q != 8'hFF)
        drop_count_q <= drop_count_q + 8'd1;
      case (state_q)
        S_OPEN: begin
          mask_q <= mask_q | hit_q;
          if (cnt_q == 8'd1) state_q <= S_COMMIT;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        S_IDLE, S_COMMIT: begin
          // A hit landing on the commit cycle starts the next window immediately.
          if (|hit_q) begin
            ts_evt_q <= ts_q;
            mask_q   <= hit_q;
            cnt_q    <= CNT_INIT;
            state_q  <= (WINDOW == 1) ? S_COMMIT : S_OPEN;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- event FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) begin
        mem_q[wr_ptr_q] <= {mask_q, ts_evt_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_wr, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- serializer
  logic [EW-1:0]   rec_q;
  logic [2:0]      idx_q;
  logic            byte_valid_q;
  logic [7:0]      byte_data_q;
  logic [23:0]     rec_ts24;
  logic [N_CH-1:0] rec_mask;
  logic [7:0]      next_byte;
  logic            xfer;

  // Timestamp field is always three bytes; narrower counters are zero-extended.
  assign rec_ts24 = 24'(rec_q[TS_WIDTH-1:0]);
  assign rec_mask = rec_q[EW-1 -: N_CH];
  assign xfer     = byte_valid_q & byte_ready;
  assign fifo_pop = xfer & (idx_q == 3'd4);

  always_comb begin
    next_byte = 8'h00;
    case (idx_q)
      3'd0:    next_byte = 8'(rec_mask);
      3'd1:    next_byte = rec_ts24[23:16];
      3'd2:    next_byte = rec_ts24[15:8];
      default: next_byte = rec_ts24[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q        <= '0;
      idx_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
    end else if (!byte_valid_q) begin
      if (!fifo_empty) begin
        rec_q        <= mem_q[rd_ptr_q];
        idx_q        <= '0;
        byte_valid_q <= 1'b1;
        byte_data_q  <= SYNC_BYTE;
      end
    end else if (xfer) begin
      if (idx_q == 3'd4) begin
        byte_valid_q <= 1'b0;
      end else begin
        idx_q       <= idx_q + 3'd1;
        byte_data_q <= next_byte;
      end
    end
  end

  assign byte_data    = byte_data_q;
  assign byte_valid   = byte_valid_q;
  assign event_strobe = event_strobe_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_coinc_event_framer.sv
// Directed bench for coinc_event_framer; a 12-bit timestamp keeps the wrap case short,
// records still carry three timestamp bytes (upper byte zero).
module tb_coinc_event_framer;
  localparam int TSW = 12;

  logic       clk = 1'b0;
  logic       rst_n, booted, byte_valid, byte_ready, event_strobe;
  logic [7:0] ch_in, ch_enable, byte_data, drop_count;

  int total = 0;
  int bad   = 0;

  coinc_event_framer #(.N_CH(8), .TS_WIDTH(TSW), .WINDOW(8), .MIN_FOLD(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .booted(booted), .ch_in(ch_in), .ch_enable(ch_enable),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .event_strobe(event_strobe), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference timestamp: counts while booted, forced to 0 otherwise.
  logic [TSW-1:0] tb_ts;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tb_ts <= '0;
    else if (booted) tb_ts <= tb_ts + 1'b1;
    else             tb_ts <= '0;
  end

  logic [7:0] rx[$];
  int strobes = 0;
  int rise_ts = -1;
  logic pv = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (byte_valid && byte_ready) rx.push_back(byte_data);
      if (event_strobe) strobes++;
      if (byte_valid && !pv) rise_ts = int'(tb_ts);
    end
    pv = byte_valid;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ts(input int target);
    int g = 0;
    while (int'(tb_ts) != target && g < 6000) begin tick(); g++; end
    total++;
    if (g >= 6000) begin bad++; $display("FAIL wait_ts got=%0d want=%0d", tb_ts, target); end
  endtask

  task automatic wait_bytes(input int n, input string nm);
    int g = 0;
    while (rx.size() < n && g < 600) begin tick(); g++; end
    total++;
    if (rx.size() < n) begin bad++; $display("FAIL %s bytes got=%0d want=%0d", nm, rx.size(), n); end
  endtask

  task automatic test_reset();
    total += 4;
    if (byte_valid !== 1'b0)    begin bad++; $display("FAIL rst_valid got=%b want=0", byte_valid); end
    if (byte_data !== 8'h00)    begin bad++; $display("FAIL rst_data got=%h want=00", byte_data); end
    if (event_strobe !== 1'b0)  begin bad++; $display("FAIL rst_strobe got=%b want=0", event_strobe); end
    if (drop_count !== 8'h00)   begin bad++; $display("FAIL rst_drop got=%h want=00", drop_count); end
  endtask

  task automatic test_basic();
    int b = rx.size();
    int s = strobes;
    logic [39:0] got;
    byte_ready = 1'b1;
    wait_ts(97);  ch_in = 8'h01;
    wait_ts(102); ch_in = 8'h08;
    repeat (3) tick();
    ch_in = 8'h00;
    wait_bytes(b + 5, "basic");
    repeat (10) tick();
    got = (rx.size() >= b + 5) ? {rx[b], rx[b+1], rx[b+2], rx[b+3], rx[b+4]} : 40'h0;
    total += 4;
    if (got !== 40'hA5_09_00_00_64) begin bad++; $display("FAIL basic_rec got=%h want=a509000064", got); end
    if (strobes - s !== 1)          begin bad++; $display("FAIL basic_strobe got=%0d want=1", strobes - s); end
    if (rise_ts !== 110)            begin bad++; $display("FAIL basic_latency got=%0d want=110", rise_ts); end
    if (rx.size() !== b + 5)        begin bad++; $display("FAIL basic_count got=%0d want=%0d", rx.size(), b + 5); end
  endtask

  task automatic test_no_event();
    int b = rx.size();
    int s = strobes;
    wait_ts(200); ch_in = 8'h01; repeat (2) tick(); ch_in = 8'h00;
    // ch1 hit lands exactly on the commit cycle of the ch0 window
    wait_ts(300); ch_in = 8'h01; repeat (2) tick(); ch_in = 8'h00;
    wait_ts(308); ch_in = 8'h02; repeat (2) tick(); ch_in = 8'h00;
    repeat (30) tick();
    total += 3;
    if (rx.size() !== b)     begin bad++; $display("FAIL noev_bytes got=%0d want=%0d", rx.size(), b); end
    if (strobes !== s)       begin bad++; $display("FAIL noev_strobe got=%0d want=%0d", strobes, s); end
    if (drop_count !== 8'h0) begin bad++; $display("FAIL noev_drop got=%h want=00", drop_count); end
  endtask

  task automatic test_window_edge();
    int b = rx.size();
    logic [39:0] got;
    // second hit on the last cycle of the window (H+7) joins the event
    wait_ts(400); ch_in = 8'h01; repeat (2) tick(); ch_in = 8'h00;
    wait_ts(407); ch_in = 8'h04; repeat (2) tick(); ch_in = 8'h00;
    wait_bytes(b + 5, "edge");
    got = (rx.size() >= b + 5) ? {rx[b], rx[b+1], rx[b+2], rx[b+3], rx[b+4]} : 40'h0;
    total++;
    if (got !== 40'hA5_05_00_01_93) begin bad++; $display("FAIL edge_rec got=%h want=a505000193", got); end
  endtask

  task automatic test_enable();
    int b = rx.size();
    int s = strobes;
    logic [39:0] got;
    ch_enable = 8'hFE;
    wait_ts(500); ch_in = 8'h03; repeat (2) tick(); ch_in = 8'h00;
    repeat (20) tick();
    total += 2;
    if (rx.size() !== b) begin bad++; $display("FAIL en_masked_bytes got=%0d want=%0d", rx.size(), b); end
    if (strobes !== s)   begin bad++; $display("FAIL en_masked_strobe got=%0d want=%0d", strobes, s); end
    ch_enable = 8'hFF;
    wait_ts(600); ch_in = 8'h03; repeat (2) tick(); ch_in = 8'h00;
    wait_bytes(b + 5, "enable");
    got = (rx.size() >= b + 5) ? {rx[b], rx[b+1], rx[b+2], rx[b+3], rx[b+4]} : 40'h0;
    total++;
    if (got !== 40'hA5_03_00_02_5B) begin bad++; $display("FAIL en_rec got=%h want=a50300025b", got); end
  endtask

  task automatic test_backpressure();
    int b = rx.size();
    int s = strobes;
    logic [39:0] got, exp;
    byte_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      wait_ts(700 + 20 * k); ch_in = 8'h05; repeat (2) tick(); ch_in = 8'h00;
    end
    wait_ts(1045);
    total += 2;
    if (drop_count !== 8'd1) begin bad++; $display("FAIL bp_drop got=%0d want=1", drop_count); end
    if (strobes - s !== 16)  begin bad++; $display("FAIL bp_strobe got=%0d want=16", strobes - s); end
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({byte_valid, byte_data} !== 9'h1A5) begin
        bad++; $display("FAIL bp_hold got=%b/%h want=1/a5", byte_valid, byte_data);
      end
      tick();
    end
    byte_ready = 1'b1;
    wait_bytes(b + 80, "bp_drain");
    repeat (20) tick();
    total++;
    if (rx.size() !== b + 80) begin bad++; $display("FAIL bp_count got=%0d want=%0d", rx.size(), b + 80); end
    for (int k = 0; k < 16; k++) begin
      int o = b + 5 * k;
      got = (rx.size() >= o + 5) ? {rx[o], rx[o+1], rx[o+2], rx[o+3], rx[o+4]} : 40'h0;
      exp = {8'hA5, 8'h05, 8'h00, 16'(703 + 20 * k)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL bp_rec%0d got=%h want=%h", k, got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    int b;
    byte_ready = 1'b0;
    wait_ts(1300); ch_in = 8'h03; repeat (2) tick(); ch_in = 8'h00;
    while (!byte_valid && g < 50) begin tick(); g++; end
    b = rx.size();
    byte_ready = 1'b1;
    tick(); tick();
    byte_ready = 1'b0;
    total++;
    if (rx.size() !== b + 2) begin bad++; $display("FAIL mid_pre got=%0d want=%0d", rx.size(), b + 2); end
    rst_n = 1'b0;
    #1;
    total += 2;
    if (byte_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", byte_valid); end
    if (byte_data !== 8'h00) begin bad++; $display("FAIL mid_data got=%h want=00", byte_data); end
    #2 rst_n = 1'b1;
    b = rx.size();
    byte_ready = 1'b1;
    repeat (40) tick();
    total += 3;
    if (rx.size() !== b)     begin bad++; $display("FAIL mid_resid got=%0d want=%0d", rx.size(), b); end
    if (byte_valid !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b want=0", byte_valid); end
    if (drop_count !== 8'h0) begin bad++; $display("FAIL mid_drop got=%h want=00", drop_count); end
  endtask

  task automatic test_booted_wrap();
    int b, s;
    logic [39:0] got;
    booted = 1'b0;
    repeat (3) tick();
    b = rx.size(); s = strobes;
    ch_in = 8'hFF; repeat (2) tick(); ch_in = 8'h00;
    repeat (30) tick();
    total += 2;
    if (rx.size() !== b) begin bad++; $display("FAIL unbooted_bytes got=%0d want=%0d", rx.size(), b); end
    if (strobes !== s)   begin bad++; $display("FAIL unbooted_strobe got=%0d want=%0d", strobes, s); end
    booted = 1'b1;
    wait_ts((1 << TSW) - 2); ch_in = 8'h03; repeat (2) tick(); ch_in = 8'h00;
    wait_bytes(b + 5, "wrap");
    got = (rx.size() >= b + 5) ? {rx[b], rx[b+1], rx[b+2], rx[b+3], rx[b+4]} : 40'h0;
    total++;
    if (got !== 40'hA5_03_00_00_01) begin bad++; $display("FAIL wrap_rec got=%h want=a503000001", got); end
  endtask

  initial begin
    rst_n = 1'b0; booted = 1'b0; ch_in = 8'h00; ch_enable = 8'hFF; byte_ready = 1'b0;
    #12;
    test_reset();
    #10 rst_n = 1'b1;
    tick();
    booted = 1'b1;
    test_basic();
    test_no_event();
    test_window_edge();
    test_enable();
    test_backpressure();
    test_reset_mid();
    test_booted_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
